// File: rtl/gba_vram_drawer_server.sv
// Round-robin VRAM read server for CLIENTS drawer ports; miss latency 3 cycles, one read issued per cycle.
// No backpressure: clients poll client_valid. Define VRAM_SNOOP_EN to invalidate held words on snooped writes.
module gba_vram_drawer_server #(
  parameter int CLIENTS  = 4,
  parameter int ADDRBITS = 14
) (
  input  logic                        fclk,
  input  logic                        reset,
  input  logic [CLIENTS*ADDRBITS-1:0] client_addr,
  output logic [CLIENTS*32-1:0]       client_data,
  output logic [CLIENTS-1:0]          client_valid,
  output logic [ADDRBITS-1:0]         vram_addr,
  output logic                        vram_rden,
  input  logic [31:0]                 vram_q,
  input  logic                        wr_en,
  input  logic [ADDRBITS-1:0]         wr_addr
);

  localparam int CW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  typedef logic [CW-1:0]       cidx_t;
  typedef logic [ADDRBITS-1:0] addr_t;

  addr_t              held_addr_q [CLIENTS];
  addr_t              held_addr_d [CLIENTS];
  logic [31:0]        held_data_q [CLIENTS];
  logic [31:0]        held_data_d [CLIENTS];
  logic [CLIENTS-1:0] held_ok_q, held_ok_d;
  logic [CLIENTS-1:0] pending_q, pending_d;

  // Issue stage (aligned with vram_rden) and return stage (aligned with vram_q)
  logic  if_vld_q, if_vld_d;
  cidx_t if_client_q, if_client_d;
  addr_t if_addr_q, if_addr_d;
  logic  if_stale_q, if_stale_d;
  logic  rd_vld_q, rd_vld_d;
  cidx_t rd_client_q, rd_client_d;
  addr_t rd_addr_q, rd_addr_d;
  logic  rd_stale_q, rd_stale_d;

  cidx_t rr_ptr_q, rr_ptr_d;
  addr_t vram_addr_q, vram_addr_d;
  logic  vram_rden_q, vram_rden_d;

  addr_t              caddr [CLIENTS];
  logic [CLIENTS-1:0] need;
  logic               gnt_vld;
  cidx_t              gnt_idx;
  logic [CLIENTS-1:0] wr_hit_held;
  logic               wr_hit_if;
  logic               wr_hit_rd;

  for (genvar i = 0; i < CLIENTS; i++) begin : g_client
    assign caddr[i]                = client_addr[i*ADDRBITS +: ADDRBITS];
    assign client_data[i*32 +: 32] = held_data_q[i];
    assign client_valid[i]         = held_ok_q[i] & (held_addr_q[i] == caddr[i]);
  end

  assign need      = ~client_valid & ~pending_q;
  assign vram_addr = vram_addr_q;
  assign vram_rden = vram_rden_q;

`ifdef VRAM_SNOOP_EN
  for (genvar i = 0; i < CLIENTS; i++) begin : g_snoop
    assign wr_hit_held[i] = wr_en & (wr_addr == held_addr_q[i]);
  end
  // A write racing the BRAM read makes the returned word untrustworthy
  assign wr_hit_if = wr_en & if_vld_q & (wr_addr == if_addr_q);
  assign wr_hit_rd = wr_en & rd_vld_q & (wr_addr == rd_addr_q);
`else
  logic unused_snoop;
  assign unused_snoop = wr_en ^ (^wr_addr);
  assign wr_hit_held  = '0;
  assign wr_hit_if    = 1'b0;
  assign wr_hit_rd    = 1'b0;
`endif

  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= CLIENTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= CLIENTS) idx = idx - CLIENTS;
      if (!gnt_vld && need[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cidx_t'(idx);
      end
    end
  end

  always_comb begin
    held_addr_d = held_addr_q;
    held_data_d = held_data_q;
    held_ok_d   = held_ok_q & ~wr_hit_held;
    pending_d   = pending_q;
    rr_ptr_d    = rr_ptr_q;
    vram_addr_d = vram_addr_q;
    vram_rden_d = gnt_vld;

    if_vld_d    = gnt_vld;
    if_client_d = gnt_idx;
    if_addr_d   = caddr[gnt_idx];
    if_stale_d  = 1'b0;

    rd_vld_d    = if_vld_q;
    rd_client_d = if_client_q;
    rd_addr_d   = if_addr_q;
    rd_stale_d  = if_stale_q | wr_hit_if;

    if (gnt_vld) begin
      vram_addr_d        = caddr[gnt_idx];
      pending_d[gnt_idx] = 1'b1;
      rr_ptr_d           = gnt_idx;
    end

    // Held address is the one actually read, so a client that moved on misses and reissues
    if (rd_vld_q) begin
      held_data_d[rd_client_q] = vram_q;
      held_addr_d[rd_client_q] = rd_addr_q;
      held_ok_d[rd_client_q]   = ~rd_stale_q & ~wr_hit_rd;
      pending_d[rd_client_q]   = 1'b0;
    end
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CLIENTS; i++) begin
        held_addr_q[i] <= '0;
        held_data_q[i] <= '0;
      end
      held_ok_q   <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= cidx_t'(CLIENTS - 1);
      vram_addr_q <= '0;
      vram_rden_q <= 1'b0;
      if_vld_q    <= 1'b0;
      if_client_q <= '0;
      if_addr_q   <= '0;
      if_stale_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_client_q <= '0;
      rd_addr_q   <= '0;
      rd_stale_q  <= 1'b0;
    end else begin
      held_addr_q <= held_addr_d;
      held_data_q <= held_data_d;
      held_ok_q   <= held_ok_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      vram_addr_q <= vram_addr_d;
      vram_rden_q <= vram_rden_d;
      if_vld_q    <= if_vld_d;
      if_client_q <= if_client_d;
      if_addr_q   <= if_addr_d;
      if_stale_q  <= if_stale_d;
      rd_vld_q    <= rd_vld_d;
      rd_client_q <= rd_client_d;
      rd_addr_q   <= rd_addr_d;
      rd_stale_q  <= rd_stale_d;
    end
  end

endmodule

// File: tb/tb_gba_vram_drawer_server.sv
// Bench for gba_vram_drawer_server: per-client scoreboard queues fed on address change, directed timing checks.
module tb_gba_vram_drawer_server;
  localparam int CLIENTS  = 4;
  localparam int ADDRBITS = 14;
  localparam int LIMIT    = 16;

  logic                        fclk = 1'b0;
  logic                        reset;
  logic [CLIENTS*ADDRBITS-1:0] client_addr;
  logic [CLIENTS*32-1:0]       client_data;
  logic [CLIENTS-1:0]          client_valid;
  logic [ADDRBITS-1:0]         vram_addr;
  logic                        vram_rden;
  logic [31:0]                 vram_q;
  logic                        wr_en;
  logic [ADDRBITS-1:0]         wr_addr;

  logic [31:0] mem [0:(1<<ADDRBITS)-1];

  typedef struct {
    logic [ADDRBITS-1:0] addr;
    logic [31:0]         data;
    int                  t;
  } exp_t;
  exp_t sbq [CLIENTS][$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en  = 1'b0;
  bit prop_en = 1'b0;

  gba_vram_drawer_server #(.CLIENTS(CLIENTS), .ADDRBITS(ADDRBITS)) dut (
    .fclk(fclk), .reset(reset), .client_addr(client_addr), .client_data(client_data),
    .client_valid(client_valid), .vram_addr(vram_addr), .vram_rden(vram_rden),
    .vram_q(vram_q), .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  // Synchronous VRAM: data one cycle after the strobe; writes are applied by the stimulus process
  always @(posedge fclk) if (vram_rden) vram_q <= mem[vram_addr];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [ADDRBITS-1:0] cur_addr(int i);
    return client_addr[i*ADDRBITS +: ADDRBITS];
  endfunction

  task automatic set_addr(int i, logic [ADDRBITS-1:0] a);
    if (a != cur_addr(i)) begin
      client_addr[i*ADDRBITS +: ADDRBITS] = a;
      sbq[i].push_back('{addr: a, data: mem[a], t: cyc});
    end
  endtask

  task automatic drv();
    @(posedge fclk);
    #1;
  endtask

  task automatic nxt();
    @(posedge fclk);
    #2;
  endtask

  task automatic wait_all_valid();
    for (int n = 0; n < 40; n++) begin
      nxt();
      if (&client_valid) break;
    end
    check("all_valid", 64'(&client_valid), 64'd1);
  endtask

  task automatic drain();
    int left;
    left = 0;
    for (int n = 0; n < 40; n++) begin
      nxt();
      left = 0;
      for (int i = 0; i < CLIENTS; i++) left += sbq[i].size();
      if (left == 0) break;
    end
    check("sb_drain", 64'(left), 64'd0);
  endtask

  // Monitor: superseded requests are dropped; the live one must turn valid with the expected word
  always @(negedge fclk) begin
    logic [ADDRBITS-1:0] a;
    if (mon_en && !reset) begin
      for (int i = 0; i < CLIENTS; i++) begin
        a = cur_addr(i);
        while (sbq[i].size() > 0 && sbq[i][0].addr != a) void'(sbq[i].pop_front());
        if (sbq[i].size() > 0) begin
          if (client_valid[i]) begin
            check("sb_data", 64'(client_data[i*32 +: 32]), 64'(sbq[i][0].data));
            void'(sbq[i].pop_front());
          end else if (cyc - sbq[i][0].t > LIMIT) begin
            checks++;
            errors++;
            $display("FAIL sb_timeout: client %0d addr %h still not valid after %0d cycles, required within %0d",
                     i, a, cyc - sbq[i][0].t, LIMIT);
            void'(sbq[i].pop_front());
          end
        end
        if (prop_en && client_valid[i])
          check("valid_data", 64'(client_data[i*32 +: 32]), 64'(mem[a]));
      end
    end
  end

  initial begin
    int pulses;
    reset       = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = '0;
    client_addr = '0;
    for (int a = 0; a < (1 << ADDRBITS); a++) mem[a] = $urandom;
    mem[14'h100] = 32'hDEADBEEF;
    repeat (3) @(posedge fclk);
    #1;
    check("rst_valid", 64'(client_valid), 64'd0);
    check("rst_rden", 64'(vram_rden), 64'd0);
    check("rst_vaddr", 64'(vram_addr), 64'd0);
    check("rst_data", 64'(|client_data), 64'd0);

    // Single miss on client 0; others queued behind it
    set_addr(0, 14'h100);
    set_addr(1, 14'h110);
    set_addr(2, 14'h120);
    set_addr(3, 14'h130);
    mon_en  = 1'b1;
    prop_en = 1'b1;
    reset   = 1'b0;
    nxt();
    check("t1_issue", {vram_rden, vram_addr}, {1'b1, 14'h100});
    nxt();
    check("t1_c2_invalid", 64'(client_valid[0]), 64'd0);
    nxt();
    check("t1_c3_valid", 64'(client_valid[0]), 64'd1);
    check("t1_c3_data", 64'(client_data[31:0]), 64'hDEADBEEF);
    wait_all_valid();

    // All four miss together: issue in order 0..3
    drv();
    for (int i = 0; i < CLIENTS; i++) set_addr(i, ADDRBITS'((i + 1) * 16));
    for (int k = 1; k <= 6; k++) begin
      nxt();
      if (k <= 4) check("t2_issue_order", {vram_rden, vram_addr}, {1'b1, ADDRBITS'(k * 16)});
      if (k == 5) check("t2_c3_early", 64'(client_valid[3]), 64'd0);
      if (k == 6) begin
        check("t2_c3_valid", 64'(client_valid[3]), 64'd1);
        check("t2_c3_data", 64'(client_data[3*32 +: 32]), 64'(mem[14'h40]));
      end
    end

    // Cache hit: unchanged addresses generate no traffic
    drv();
    set_addr(1, 14'h200);
    wait_all_valid();
    pulses = 0;
    repeat (50) begin
      nxt();
      if (vram_rden) pulses++;
    end
    check("t3_hit_no_traffic", 64'(pulses), 64'd0);

    // Address moves while the read is in flight
    drv();
    set_addr(2, 14'h300);
    nxt();
    check("t4_issue", {vram_rden, vram_addr}, {1'b1, 14'h300});
    set_addr(2, 14'h301);
    for (int k = 2; k <= 6; k++) begin
      nxt();
      if (k <= 5) check("t4_no_stale_valid", 64'(client_valid[2]), 64'd0);
      if (k == 4) check("t4_reissue", {vram_rden, vram_addr}, {1'b1, 14'h301});
      if (k == 6) begin
        check("t4_valid", 64'(client_valid[2]), 64'd1);
        check("t4_data", 64'(client_data[2*32 +: 32]), 64'(mem[14'h301]));
      end
    end

    // Randomised address churn against the scoreboard
    repeat (400) begin
      drv();
      for (int i = 0; i < CLIENTS; i++)
        if ($urandom_range(0, 7) == 0) set_addr(i, ADDRBITS'(14'h400 + $urandom_range(0, 63)));
    end
    drain();

    // Snooped write to a held address
    drv();
    set_addr(0, 14'h100);
    wait_all_valid();
    drain();
    prop_en = 1'b0;
    drv();
    wr_en   = 1'b1;
    wr_addr = 14'h100;
    drv();
    mem[14'h100] = 32'hCAFEF00D;
    wr_en = 1'b0;
    #1;
`ifdef VRAM_SNOOP_EN
    check("t5_snoop_drop", 64'(client_valid[0]), 64'd0);
    nxt();
    check("t5_snoop_reissue", {vram_rden, vram_addr}, {1'b1, 14'h100});
    nxt();
    nxt();
    check("t5_snoop_valid", 64'(client_valid[0]), 64'd1);
    check("t5_snoop_data", 64'(client_data[31:0]), 64'hCAFEF00D);
`else
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      check("t5_nosnoop_hold", {client_valid[0], client_data[31:0]}, {1'b1, 32'hDEADBEEF});
      if (vram_rden) pulses++;
      nxt();
    end
    check("t5_nosnoop_traffic", 64'(pulses), 64'd0);
`endif

    // Reset during an in-flight read
    drv();
    set_addr(1, 14'h500);
    nxt();
    check("t6_issue", {vram_rden, vram_addr}, {1'b1, 14'h500});
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 64'(client_valid), 64'd0);
    check("t6_rst_rden", 64'(vram_rden), 64'd0);
    for (int i = 0; i < CLIENTS; i++) sbq[i].delete();
    repeat (2) @(posedge fclk);
    #1;
    for (int i = 0; i < CLIENTS; i++) sbq[i].push_back('{addr: cur_addr(i), data: mem[cur_addr(i)], t: cyc});
    reset   = 1'b0;
    prop_en = 1'b1;
    nxt();
    check("t6_no_capture_c1", 64'(client_valid), 64'd0);
    check("t6_first_issue", {vram_rden, vram_addr}, {1'b1, 14'h100});
    nxt();
    check("t6_no_capture_c2", 64'(client_valid), 64'd0);
    wait_all_valid();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
